// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: MULT/MULTU/DIV/DIVU engine that owns HI/LO and accepts MTHI/MTLO writes.
// Define HILO_MULDIV_DIV_EN to build the restoring divider; without it DIV/DIVU finish at once with HI/LO untouched.
module hilo_muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + MUL_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg_q;
  logic               accept, sgn, mul_last, wr_ok;
  logic [2*WIDTH-1:0] prod_mag, prod;

  assign accept   = start && (state == S_IDLE || state == S_DONE);
  assign wr_ok    = !start && (state == S_IDLE || state == S_DONE);
  assign sgn      = ~op[0];
  assign mul_last = (state == S_MUL) && (cnt == CW'(MUL_LAT - 1));
  assign prod_mag = (2*WIDTH)'(mag_a) * (2*WIDTH)'(mag_b);
  assign prod     = neg_q ? -prod_mag : prod_mag;

`ifdef HILO_MULDIV_DIV_EN
  logic [WIDTH-1:0] rem;
  logic             neg_r, div_zero;
  logic [WIDTH:0]   shifted, trial;

  // mag_a doubles as the dividend shift register and collects quotient bits from the right
  assign shifted = {rem, mag_a[WIDTH-1]};
  assign trial   = shifted - {1'b0, mag_b};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        state_nx = S_IDLE;
        if (start) begin
`ifdef HILO_MULDIV_DIV_EN
          state_nx = op[1] ? S_DIV : S_MUL;
`else
          state_nx = op[1] ? S_DONE : S_MUL;
`endif
        end
      end
      S_MUL: if (cnt == CW'(MUL_LAT - 1)) state_nx = S_DONE;
`ifdef HILO_MULDIV_DIV_EN
      S_DIV: if (cnt == CW'(WIDTH - 1)) state_nx = S_FIX;
      S_FIX: state_nx = S_DONE;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      neg_q    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef HILO_MULDIV_DIV_EN
      rem      <= '0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      if (accept) begin
        cnt      <= '0;
        mag_a    <= (sgn && a[WIDTH-1]) ? -a : a;
        mag_b    <= (sgn && b[WIDTH-1]) ? -b : b;
        neg_q    <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef HILO_MULDIV_DIV_EN
        rem      <= '0;
        neg_r    <= sgn && a[WIDTH-1];
        div_zero <= (b == '0);
      end else if (state == S_DIV) begin
        cnt <= cnt + CW'(1);
        if (!trial[WIDTH]) begin
          rem   <= trial[WIDTH-1:0];
          mag_a <= {mag_a[WIDTH-2:0], 1'b1};
        end else begin
          rem   <= shifted[WIDTH-1:0];
          mag_a <= {mag_a[WIDTH-2:0], 1'b0};
        end
`endif
      end else if (state == S_MUL) begin
        cnt <= cnt + CW'(1);
      end

      if (mul_last) begin
        hi <= prod[2*WIDTH-1:WIDTH];
        lo <= prod[WIDTH-1:0];
      end
`ifdef HILO_MULDIV_DIV_EN
      // divide by zero leaves an all-ones quotient unsigned; the remainder already equals a
      else if (state == S_FIX) begin
        hi <= neg_r ? -rem : rem;
        lo <= div_zero ? '1 : (neg_q ? -mag_a : mag_a);
      end
`endif
      else if (wr_ok) begin
        if (hi_we) hi <= wd;
        if (lo_we) lo <= wd;
      end
    end
  end

endmodule
